// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced single-button operand loader for the lab ALU.
// A push button walks a 4-state FSM that captures operand A, operand B, then
// the operation selector and carry-in from the board switches. The ALU inputs
// are presented as stable registered values.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset
//   btn_n     in   1  raw push button, active-low
//   sw        in   N  raw operand switches
//   op_sw     in   4  raw operation switches (forwarded unmodified)
//   cin_sw    in   1  raw carry-in switch
//   a         out  N  registered operand A
//   b         out  N  registered operand B
//   selector  out  4  registered operation code
//   Cin       out  1  registered carry-in
//   valid     out  1  high while a complete operand set is being executed
//   step      out  2  current FSM state, for LEDs
module alu_operand_loader #(
    parameter int unsigned N          = 4,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_n,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         cin_sw,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   selector,
    output logic         Cin,
    output logic         valid,
    output logic [1:0]   step
);

    localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [3:0]    SEL_RESET = 4'b1111;

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_OP  = 2'b10,
        S_RUN = 2'b11
    } state_t;

    // Button synchronizer and debouncer state
    logic          sync1_q, sync2_q;
    logic          deb_level_q, deb_level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_prev_q;

    // Arming: after reset the button must be seen released before a press counts
    logic [1:0]    sync_ok_q;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic          armed_q, armed_d;

    logic          press;

    // FSM and captured operand registers
    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [3:0]    sel_q, sel_d;
    logic          cin_q, cin_d;
    logic          valid_q, valid_d;

    // Debounce: a new level must persist for DEB_CYCLES synchronized cycles
    always_comb begin
        deb_level_d = deb_level_q;
        cnt_d       = cnt_q;
        if (sync2_q == deb_level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_level_d = sync2_q;
            cnt_d       = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Arm once DEB_CYCLES real (post-reset) released samples are observed.
    // sync_ok_q[1] marks that sync2 no longer holds its reset value.
    always_comb begin
        rel_cnt_d = rel_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            if (sync_ok_q[1] && sync2_q) begin
                if (rel_cnt_q == CNT_LAST) begin
                    armed_d   = 1'b1;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q + CW'(1);
                end
            end else begin
                rel_cnt_d = '0;
            end
        end
    end

    // One-cycle pulse on an accepted debounced falling edge
    assign press = deb_prev_q & ~deb_level_q & armed_q;

    // Capture FSM next state and next register values
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        if (press) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    sel_d   = op_sw;
                    cin_d   = cin_sw;
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    // All state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_level_q <= 1'b1;
            cnt_q       <= '0;
            deb_prev_q  <= 1'b1;
            sync_ok_q   <= '0;
            rel_cnt_q   <= '0;
            armed_q     <= 1'b0;
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= SEL_RESET;
            cin_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            deb_level_q <= deb_level_d;
            cnt_q       <= cnt_d;
            deb_prev_q  <= deb_level_q;
            sync_ok_q   <= {sync_ok_q[0], 1'b1};
            rel_cnt_q   <= rel_cnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            cin_q       <= cin_d;
            valid_q     <= valid_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign selector = sel_q;
    assign Cin      = cin_q;
    assign valid    = valid_q;
    assign step     = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed button/switch stimulus, a
// history-based behavioural model compared every cycle, plus literal checks.
module tb_alu_operand_loader;

    localparam int N   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_n;
    logic [N-1:0] sw;
    logic [3:0]   op_sw;
    logic         cin_sw;
    logic [N-1:0] a, b;
    logic [3:0]   selector;
    logic         Cin, valid;
    logic [1:0]   step;

    alu_operand_loader #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .sw(sw), .op_sw(op_sw),
        .cin_sw(cin_sw), .a(a), .b(b), .selector(selector), .Cin(Cin),
        .valid(valid), .step(step)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: keeps the raw button sample seen at every edge since reset and
    // decides level changes from runs of DEB_CYCLES synchronized samples.
    bit           hist[$];
    int           m_e;
    bit           m_level, m_armed, m_pend;
    bit           all_diff, all_high;
    logic [N-1:0] m_a, m_b;
    logic [3:0]   m_sel;
    logic         m_cin, m_valid;
    logic [1:0]   m_step;

    // Synchronized sample used at edge e is the raw sample from edge e-2
    function automatic bit smp(input int k);
        if (k < 1) return 1'b1;
        return hist[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            hist.push_back(1'b1);
            m_e = 0; m_level = 1'b1; m_armed = 1'b0; m_pend = 1'b0;
            m_a = '0; m_b = '0; m_sel = 4'b1111; m_cin = 1'b0;
            m_valid = 1'b0; m_step = 2'd0;
        end else begin
            m_e++;
            hist.push_back(btn_n);
            if (m_pend) begin
                m_pend = 1'b0;
                case (m_step)
                    2'd0: begin m_a = sw; m_step = 2'd1; end
                    2'd1: begin m_b = sw; m_step = 2'd2; end
                    2'd2: begin m_sel = op_sw; m_cin = cin_sw; m_valid = 1'b1; m_step = 2'd3; end
                    default: begin m_valid = 1'b0; m_step = 2'd0; end
                endcase
            end
            all_diff = 1'b1;
            all_high = 1'b1;
            for (int k = m_e - 1 - DEB; k <= m_e - 2; k++) begin
                if (smp(k) == m_level) all_diff = 1'b0;
                if (k < 1 || smp(k) == 1'b0) all_high = 1'b0;
            end
            if (all_high) m_armed = 1'b1;
            if (all_diff) begin
                if (m_level && m_armed) m_pend = 1'b1;
                m_level = ~m_level;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_a", 32'(a), 32'(m_a));
            chk("m_b", 32'(b), 32'(m_b));
            chk("m_selector", 32'(selector), 32'(m_sel));
            chk("m_Cin", 32'(Cin), 32'(m_cin));
            chk("m_valid", 32'(valid), 32'(m_valid));
            chk("m_step", 32'(step), 32'(m_step));
        end
    end

    task automatic idle(input int n);
        btn_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_press(input logic [N-1:0] s);
        sw    = s;
        btn_n = 1'b0;
        repeat (12) @(negedge clk);
        idle(12);
    endtask

    initial begin
        rst = 1'b1; btn_n = 1'b1; sw = '0; op_sw = 4'b0000; cin_sw = 1'b0;
        @(negedge clk);
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        chk("rst_sel", 32'(selector), 32'hF);
        chk("rst_cin", 32'(Cin), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        rst = 1'b0;
        idle(10);

        // Full sequence
        do_press(4'h3);
        chk("seq_a", 32'(a), 32'h3);
        chk("seq_step1", 32'(step), 32'h1);
        do_press(4'h5);
        chk("seq_b", 32'(b), 32'h5);
        chk("seq_step2", 32'(step), 32'h2);
        op_sw = 4'b1111; cin_sw = 1'b0; btn_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("lat_valid_pre", 32'(valid), 32'h0);
        chk("lat_step_pre", 32'(step), 32'h2);
        @(negedge clk);
        chk("lat_valid_e7", 32'(valid), 32'h1);
        chk("lat_step_e7", 32'(step), 32'h3);
        chk("seq_sel", 32'(selector), 32'hF);
        chk("seq_cin", 32'(Cin), 32'h0);
        repeat (5) @(negedge clk);
        idle(12);

        // Wrap back to S_A, operands retained
        do_press(4'hC);
        chk("wrap_valid", 32'(valid), 32'h0);
        chk("wrap_step", 32'(step), 32'h0);
        chk("wrap_a", 32'(a), 32'h3);
        chk("wrap_b", 32'(b), 32'h5);

        // Glitch shorter than the debounce window
        sw = 4'h9; btn_n = 1'b0;
        repeat (3) @(negedge clk);
        idle(12);
        chk("glitch_step", 32'(step), 32'h0);
        chk("glitch_a", 32'(a), 32'h3);

        // Held button: exactly one capture
        sw = 4'hA; btn_n = 1'b0;
        repeat (50) @(negedge clk);
        chk("held_a", 32'(a), 32'hA);
        chk("held_step", 32'(step), 32'h1);
        idle(12);

        // Bouncy press: capture DEB+3 edges after the stable low starts
        sw = 4'h6;
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0; @(negedge clk);
            btn_n = 1'b1; @(negedge clk);
        end
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("bounce_step_pre", 32'(step), 32'h1);
        @(negedge clk);
        chk("bounce_step", 32'(step), 32'h2);
        chk("bounce_b", 32'(b), 32'h6);
        repeat (5) @(negedge clk);
        idle(12);

        op_sw = 4'b0110; cin_sw = 1'b1;
        do_press(4'h0);
        chk("op2_sel", 32'(selector), 32'h6);
        chk("op2_cin", 32'(Cin), 32'h1);
        chk("op2_valid", 32'(valid), 32'h1);
        do_press(4'h0);
        chk("wrap2_sel", 32'(selector), 32'h6);
        chk("wrap2_b", 32'(b), 32'h6);
        do_press(4'hF);
        chk("wrap2_a", 32'(a), 32'hF);
        do_press(4'h7);
        chk("sop_step", 32'(step), 32'h2);

        // Async reset in S_OP mid-debounce
        btn_n = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", 32'(a), 32'h0);
        chk("arst_b", 32'(b), 32'h0);
        chk("arst_sel", 32'(selector), 32'hF);
        chk("arst_step", 32'(step), 32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_step", 32'(step), 32'h0);
        chk("post_rst_a", 32'(a), 32'h0);
        idle(12);
        do_press(4'h9);
        chk("rearm_a", 32'(a), 32'h9);
        chk("rearm_step", 32'(step), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
